voice_pool_mixer: RTL and testbench

VOICE_POOL_MIXER -- requirements
Module: voice_pool_mixer

---
 rtl/audio_pkg.sv | 18 +
 rtl/priority_select.sv | 14 +
 rtl/voice_pool_mixer.sv | 165 ++++++++++++++++
 tb/tb_voice_pool_mixer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the voice pool mixer: default widths, mix mode
// encodings and the mixer state encoding.
package audio_pkg;

  localparam int DEFAULT_NUM_VOICES = 8;
  localparam int DEFAULT_SAMPLE_W   = 16;
  localparam int DEFAULT_NOTE_W     = 15;

  localparam int MIX_AVG = 0;
  localparam int MIX_SAT = 1;

  typedef logic [1:0] mix_state_t;

  localparam mix_state_t ST_IDLE  = 2'd0;
  localparam mix_state_t ST_ACCUM = 2'd1;
  localparam mix_state_t ST_OUT   = 2'd2;

endpackage

// File: rtl/priority_select.sv
// Lowest-index one-hot grant over a request vector of any width.
module priority_select #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant,
  output logic             any
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + WIDTH'(1));
  assign any   = |req;

endmodule

// File: rtl/voice_pool_mixer.sv
// Voice allocator (free-first, round-robin steal when full) plus a
// sequential mixer that sums one captured voice per cycle.
module voice_pool_mixer
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
  parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
  parameter int NOTE_W     = DEFAULT_NOTE_W,
  parameter int MIX_MODE   = MIX_AVG
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         note_valid,
  output logic                         note_ready,
  input  logic [NOTE_W-1:0]            note_in,
  input  logic [NUM_VOICES-1:0]        voice_busy,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic [NOTE_W-1:0]            voice_note,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
  input  logic                         generate_next_sample,
  output logic                         new_sample_ready,
  output logic [SAMPLE_W-1:0]          out_sample,
  output logic [7:0]                   steal_count,
  output mix_state_t                   mix_state
);

  localparam int LOG2N = $clog2(NUM_VOICES);
  localparam int AW    = SAMPLE_W + LOG2N;
  localparam logic signed [AW-1:0] SAT_MAX = {{(LOG2N+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(LOG2N+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic                  note_ready_q, note_ready_d;
  logic [NUM_VOICES-1:0] voice_load_q, voice_load_d;
  logic [NOTE_W-1:0]     voice_note_q, voice_note_d;
  logic [LOG2N-1:0]      steal_ptr_q, steal_ptr_d;
  logic [7:0]            steal_count_q, steal_count_d;

  logic [NUM_VOICES-1:0] free_grant;
  logic [NUM_VOICES-1:0] steal_onehot;
  logic                  free_any;
  logic                  accept;

  priority_select #(.WIDTH(NUM_VOICES)) u_free_sel (
    .req   (~voice_busy),
    .grant (free_grant),
    .any   (free_any)
  );

  // Handshake: a note is taken when note_valid and note_ready are both high
  // on a rising edge; note_ready drops only in the cycle voice_load is driven.
  assign accept       = note_valid & note_ready_q;
  assign steal_onehot = NUM_VOICES'(1) << steal_ptr_q;

  always_comb begin
    note_ready_d  = 1'b1;
    voice_load_d  = '0;
    voice_note_d  = voice_note_q;
    steal_ptr_d   = steal_ptr_q;
    steal_count_d = steal_count_q;
    if (accept) begin
      note_ready_d = 1'b0;
      voice_note_d = note_in;
      if (free_any) begin
        voice_load_d = free_grant;
        // Skip a voice we just filled so it is not the next one stolen.
        if (free_grant == steal_onehot) steal_ptr_d = steal_ptr_q + LOG2N'(1);
      end else begin
        voice_load_d = steal_onehot;
        steal_ptr_d  = steal_ptr_q + LOG2N'(1);
        if (steal_count_q != 8'hFF) steal_count_d = steal_count_q + 8'd1;
      end
    end
  end

  mix_state_t                    state_q, state_d;
  logic [LOG2N-1:0]              cnt_q, cnt_d;
  logic signed [AW-1:0]          acc_q, acc_d;
  logic [NUM_VOICES*SAMPLE_W-1:0] samples_q, samples_d;
  logic [SAMPLE_W-1:0]           out_sample_q, out_sample_d;
  logic                          nsr_q, nsr_d;

  logic [SAMPLE_W-1:0]           cur_sample;
  logic signed [AW-1:0]          acc_sum;
  logic [SAMPLE_W-1:0]           mix_result;

  assign cur_sample = samples_q[cnt_q*SAMPLE_W +: SAMPLE_W];
  assign acc_sum    = acc_q + {{LOG2N{cur_sample[SAMPLE_W-1]}}, cur_sample};

  always_comb begin
    mix_result = acc_sum[LOG2N +: SAMPLE_W];
    if (MIX_MODE == MIX_SAT) begin
      if (acc_sum > SAT_MAX)      mix_result = SAT_MAX[SAMPLE_W-1:0];
      else if (acc_sum < SAT_MIN) mix_result = SAT_MIN[SAMPLE_W-1:0];
      else                        mix_result = acc_sum[SAMPLE_W-1:0];
    end
  end

  // The result is registered on the last ACCUM edge so the pulse and the
  // new sample both appear in the OUT cycle, NUM_VOICES+1 after the request.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    samples_d    = samples_q;
    out_sample_d = out_sample_q;
    nsr_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (generate_next_sample) begin
          samples_d = voice_samples;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + LOG2N'(1);
        if (cnt_q == LOG2N'(NUM_VOICES - 1)) begin
          out_sample_d = mix_result;
          nsr_d        = 1'b1;
          state_d      = ST_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      note_ready_q  <= 1'b1;
      voice_load_q  <= '0;
      voice_note_q  <= '0;
      steal_ptr_q   <= '0;
      steal_count_q <= '0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      samples_q     <= '0;
      out_sample_q  <= '0;
      nsr_q         <= 1'b0;
    end else begin
      note_ready_q  <= note_ready_d;
      voice_load_q  <= voice_load_d;
      voice_note_q  <= voice_note_d;
      steal_ptr_q   <= steal_ptr_d;
      steal_count_q <= steal_count_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      samples_q     <= samples_d;
      out_sample_q  <= out_sample_d;
      nsr_q         <= nsr_d;
    end
  end

  assign note_ready       = note_ready_q;
  assign voice_load       = voice_load_q;
  assign voice_note       = voice_note_q;
  assign steal_count      = steal_count_q;
  assign out_sample       = out_sample_q;
  assign new_sample_ready = nsr_q;
  assign mix_state        = state_q;

endmodule

// File: tb/tb_voice_pool_mixer.sv
// Bench for voice_pool_mixer: allocation scoreboard on an 8-voice instance and
// mix checks on four instances (N=8 avg, N=8 sat, N=2 avg, N=32 sat).
module tb_voice_pool_mixer;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        note_valid = 1'b0;
  logic        note_ready;
  logic [14:0] note_in = '0;
  logic [7:0]  voice_busy = '0;
  logic [7:0]  voice_load;
  logic [14:0] voice_note;
  logic [7:0]  steal_count;
  mix_state_t  mix_state0;

  logic [3:0]       gen_v = '0;
  logic [3:0]       nsr_v;
  logic [3:0][15:0] out_v;
  logic [127:0]     sb0 = '0;
  logic [127:0]     sb1 = '0;
  logic [31:0]      sb2 = '0;
  logic [511:0]     sb3 = '0;

  logic        d1_ready, d2_ready, d3_ready;
  logic [7:0]  d1_load;
  logic [1:0]  d2_load;
  logic [31:0] d3_load;
  logic [14:0] d1_note, d2_note, d3_note;
  logic [7:0]  d1_steal, d2_steal, d3_steal;
  mix_state_t  d1_state, d2_state, d3_state;

  voice_pool_mixer #(.NUM_VOICES(8), .MIX_MODE(0)) dut (
    .clk(clk), .reset(reset), .note_valid(note_valid), .note_ready(note_ready),
    .note_in(note_in), .voice_busy(voice_busy), .voice_load(voice_load),
    .voice_note(voice_note), .voice_samples(sb0), .generate_next_sample(gen_v[0]),
    .new_sample_ready(nsr_v[0]), .out_sample(out_v[0]), .steal_count(steal_count),
    .mix_state(mix_state0));

  voice_pool_mixer #(.NUM_VOICES(8), .MIX_MODE(1)) dut_sat8 (
    .clk(clk), .reset(reset), .note_valid(1'b0), .note_ready(d1_ready),
    .note_in(15'd0), .voice_busy(8'd0), .voice_load(d1_load),
    .voice_note(d1_note), .voice_samples(sb1), .generate_next_sample(gen_v[1]),
    .new_sample_ready(nsr_v[1]), .out_sample(out_v[1]), .steal_count(d1_steal),
    .mix_state(d1_state));

  voice_pool_mixer #(.NUM_VOICES(2), .MIX_MODE(0)) dut_avg2 (
    .clk(clk), .reset(reset), .note_valid(1'b0), .note_ready(d2_ready),
    .note_in(15'd0), .voice_busy(2'd0), .voice_load(d2_load),
    .voice_note(d2_note), .voice_samples(sb2), .generate_next_sample(gen_v[2]),
    .new_sample_ready(nsr_v[2]), .out_sample(out_v[2]), .steal_count(d2_steal),
    .mix_state(d2_state));

  voice_pool_mixer #(.NUM_VOICES(32), .MIX_MODE(1)) dut_sat32 (
    .clk(clk), .reset(reset), .note_valid(1'b0), .note_ready(d3_ready),
    .note_in(15'd0), .voice_busy(32'd0), .voice_load(d3_load),
    .voice_note(d3_note), .voice_samples(sb3), .generate_next_sample(gen_v[3]),
    .new_sample_ready(nsr_v[3]), .out_sample(out_v[3]), .steal_count(d3_steal),
    .mix_state(d3_state));

  int n_checks = 0;
  int n_fail   = 0;

  logic [22:0] exp_q[$];
  logic [7:0]  tb_busy = '0;
  bit          sticky = 1'b0;
  int          m_ptr = 0;
  int          m_cnt = 0;
  int          smp[32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference allocation: lowest free voice, otherwise the round-robin victim.
  function automatic logic [7:0] model_alloc(input logic [7:0] busy);
    int sel = -1;
    for (int i = 7; i >= 0; i--) if (!busy[i]) sel = i;
    if (sel < 0) begin
      sel = m_ptr;
      m_ptr = (m_ptr + 1) % 8;
      if (m_cnt < 255) m_cnt++;
    end else if (sel == m_ptr) begin
      m_ptr = (m_ptr + 1) % 8;
    end
    return 8'(1 << sel);
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ptr = 0; m_cnt = 0; tb_busy = '0;
  endtask

  task automatic offer_note(input logic [14:0] note);
    int waited = 0;
    logic [7:0]  exp_load;
    logic [22:0] e;
    @(posedge clk); #1;
    voice_busy = tb_busy;
    note_valid = 1'b1;
    note_in    = note;
    @(negedge clk);
    while (!note_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("note_ready_before_accept", 32'(note_ready), 32'd1);
    exp_load = model_alloc(tb_busy);
    exp_q.push_back({note, exp_load});
    @(posedge clk); #1;
    note_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    check("voice_load", 32'(voice_load), 32'(e[7:0]));
    check("voice_note", 32'(voice_note), 32'(e[22:8]));
    check("note_ready_turnaround", 32'(note_ready), 32'd0);
    if (sticky) tb_busy = tb_busy | exp_load;
  endtask

  task automatic drive_bus(input int idx, input int nv, input bit scramble);
    logic [15:0] v;
    for (int i = 0; i < nv; i++) begin
      v = smp[i][15:0];
      if (scramble) v = ~v;
      case (idx)
        0: sb0[i*16 +: 16] = v;
        1: sb1[i*16 +: 16] = v;
        2: sb2[i*16 +: 16] = v;
        default: sb3[i*16 +: 16] = v;
      endcase
    end
  endtask

  function automatic logic [15:0] model_mix(input int nv, input int mode);
    int sum = 0;
    int r;
    for (int i = 0; i < nv; i++) sum += smp[i];
    if (mode == 0) r = sum >>> $clog2(nv);
    else if (sum > 32767) r = 32767;
    else if (sum < -32768) r = -32768;
    else r = sum;
    return 16'(r);
  endfunction

  task automatic run_mix(input int idx, input int nv, input int mode);
    logic [15:0] exp_out;
    int lat = 1;
    bit found = 1'b0;
    exp_out = model_mix(nv, mode);
    @(posedge clk); #1;
    drive_bus(idx, nv, 1'b0);
    gen_v[idx] = 1'b1;
    @(posedge clk); #1;
    gen_v[idx] = 1'b0;
    drive_bus(idx, nv, 1'b1);
    while (!found && lat <= 40) begin
      @(negedge clk);
      if (nsr_v[idx]) found = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check($sformatf("mix%0d_pulse_seen", idx), 32'(found), 32'd1);
    if (found) begin
      check($sformatf("mix%0d_latency", idx), 32'(lat), 32'(nv + 1));
      check($sformatf("mix%0d_out", idx), 32'(out_v[idx]), 32'(exp_out));
      @(posedge clk); @(negedge clk);
      check($sformatf("mix%0d_pulse_width", idx), 32'(nsr_v[idx]), 32'd0);
      check($sformatf("mix%0d_out_held", idx), 32'(out_v[idx]), 32'(exp_out));
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 32; i++) smp[i] = v;
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int i = 0; i < 32; i++) smp[i] = int'($urandom_range(0, hi - lo)) + lo;
  endtask

  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_note_ready", 32'(note_ready), 32'd1);
    check("rst_voice_load", 32'(voice_load), 32'd0);
    check("rst_voice_note", 32'(voice_note), 32'd0);
    check("rst_out_sample", 32'(out_v[0]), 32'd0);
    check("rst_nsr", 32'(nsr_v), 32'd0);
    check("rst_steal_count", 32'(steal_count), 32'd0);
    check("rst_mix_state", 32'(mix_state0), 32'(ST_IDLE));

    // Free-path allocation with players that latch busy on load.
    sticky = 1'b1;
    offer_note(15'h011);
    offer_note(15'h022);
    offer_note(15'h033);

    // All voices busy: nine steals wrapping once.
    do_reset();
    sticky = 1'b0;
    tb_busy = 8'hFF;
    for (int i = 0; i < 9; i++) offer_note(15'(16'h100 + i));
    @(negedge clk);
    check("steal_count_9", 32'(steal_count), 32'(m_cnt));

    // Averaging, 8 voices.
    fill_const(16'h1000);
    run_mix(0, 8, 0);
    for (int k = 0; k < 3; k++) begin
      fill_random(-32768, 32767);
      run_mix(0, 8, 0);
    end

    // Allocation and mixing in the same cycles.
    fill_random(-32768, 32767);
    tb_busy = 8'($urandom);
    fork
      run_mix(0, 8, 0);
      begin
        offer_note(15'h4AB);
        offer_note(15'h0CD);
      end
    join

    // Saturating sum, 8 voices.
    fill_const(32'h7000);
    run_mix(1, 8, 1);
    fill_const(-32'h7000);
    run_mix(1, 8, 1);
    fill_random(-3000, 3000);
    run_mix(1, 8, 1);
    fill_random(-32768, 32767);
    run_mix(1, 8, 1);

    // Ramps on the smallest and largest pools.
    for (int i = 0; i < 32; i++) smp[i] = i * 1000 - 7001;
    run_mix(2, 2, 0);
    for (int i = 0; i < 32; i++) smp[i] = 30000 - i * 2000;
    run_mix(2, 2, 0);
    for (int i = 0; i < 32; i++) smp[i] = i * 100 - 1601;
    run_mix(3, 32, 1);
    for (int i = 0; i < 32; i++) smp[i] = i * 1500;
    run_mix(3, 32, 1);
    for (int i = 0; i < 32; i++) smp[i] = -i * 1500;
    run_mix(3, 32, 1);
    fill_random(-2000, 2000);
    run_mix(3, 32, 1);

    // Randomised allocation against the reference.
    for (int k = 0; k < 30; k++) begin
      tb_busy = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      offer_note(15'($urandom));
    end
    @(negedge clk);
    check("steal_count_random", 32'(steal_count), 32'(m_cnt));

    // Saturation of the steal counter.
    tb_busy = 8'hFF;
    for (int k = 0; k < 260; k++) offer_note(15'($urandom));
    @(negedge clk);
    check("steal_count_sat", 32'(steal_count), 32'd255);

    // Second request while busy is dropped.
    fill_random(-32768, 32767);
    @(posedge clk); #1;
    drive_bus(0, 8, 1'b0);
    gen_v[0] = 1'b1;
    @(posedge clk); #1;
    gen_v[0] = 1'b0;
    @(negedge clk);
    check("state_accum", 32'(mix_state0), 32'(ST_ACCUM));
    repeat (2) @(posedge clk);
    #1 gen_v[0] = 1'b1;
    @(posedge clk); #1;
    gen_v[0] = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (nsr_v[0]) pulses++;
    end
    check("single_pulse", 32'(pulses), 32'd1);
    check("single_pulse_out", 32'(out_v[0]), 32'(model_mix(8, 0)));

    // Reset in the fourth ACCUM cycle discards the sum.
    fill_const(16'h0123);
    @(posedge clk); #1;
    drive_bus(0, 8, 1'b0);
    gen_v[0] = 1'b1;
    @(posedge clk); #1;
    gen_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ptr = 0; m_cnt = 0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (nsr_v[0]) pulses++;
    end
    check("reset_no_pulse", 32'(pulses), 32'd0);
    check("reset_out_zero", 32'(out_v[0]), 32'd0);
    check("reset_state_idle", 32'(mix_state0), 32'(ST_IDLE));
    check("reset_steal_zero", 32'(steal_count), 32'd0);

    // Reset alongside an offered note cancels the load.
    @(posedge clk); #1;
    note_valid = 1'b1;
    note_in    = 15'h055;
    reset      = 1'b1;
    @(posedge clk); #1;
    note_valid = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    check("cancel_load", 32'(voice_load), 32'd0);
    check("cancel_note", 32'(voice_note), 32'd0);
    check("cancel_ready", 32'(note_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
